// File: rtl/pwm_duty_capture_pkg.sv
// Shared types and constants for the PWM duty-cycle capture block.
// Holds the measurement state encoding, counter sizing and the duty recovery helper.
package pwm_duty_capture_pkg;

    localparam int CNT_W       = 8;
    localparam int DUTY_W      = 6;
    localparam int DUTY_MAX    = 63;
    localparam int DEF_TIMEOUT = 128;
    localparam int DEF_FRAME   = 64;

    typedef enum logic [0:0] {
        SEARCH  = 1'b0,
        MEASURE = 1'b1
    } state_t;

    // Generator code is one less than the high time, saturated to the 6-bit code range.
    function automatic logic [DUTY_W-1:0] duty_of(input logic [CNT_W-1:0] hi);
        logic [CNT_W-1:0] d;
        d = hi - CNT_W'(1);
        if (d > CNT_W'(DUTY_MAX)) begin
            duty_of = DUTY_W'(DUTY_MAX);
        end else begin
            duty_of = d[DUTY_W-1:0];
        end
    endfunction

endpackage

// File: rtl/pwm_duty_capture_sync2.sv
// Two-flop synchronizer bringing the asynchronous PWM line into the clk domain.
module pwm_duty_capture_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture, cleared to 0 on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/pwm_duty_capture.sv
// Measures high time and period of an asynchronous PWM line between rising edges,
// recovers the generator code and flags a stuck line after TIMEOUT edge-free cycles.
module pwm_duty_capture
    import pwm_duty_capture_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int FRAME   = DEF_FRAME
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    output logic              valid_o,
    output logic [CNT_W-1:0]  high_o,
    output logic [CNT_W-1:0]  period_o,
    output logic [DUTY_W-1:0] duty_o,
    output logic              frame_ok_o,
    output logic              stuck_o,
    output logic              level_o
);

    localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_M1_C = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FRAME_C = CNT_W'(FRAME);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);

    logic              s_s;
    logic              s_prev_r;
    logic              rise_s;
    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  per_cnt_r;
    logic [CNT_W-1:0]  per_cnt_nxt_s;
    logic [CNT_W-1:0]  hi_cnt_r;
    logic [CNT_W-1:0]  hi_cnt_nxt_s;
    logic              valid_nxt_s;
    logic [CNT_W-1:0]  high_nxt_s;
    logic [CNT_W-1:0]  period_nxt_s;
    logic [DUTY_W-1:0] duty_nxt_s;
    logic              frame_ok_nxt_s;
    logic              stuck_nxt_s;
    logic              level_nxt_s;

    pwm_duty_capture_sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (pwm_in),
        .q   (s_s)
    );

    assign rise_s = s_s & ~s_prev_r;

    // Next state, counters and result values; a rising edge takes priority over the timeout.
    always_comb begin
        state_nxt_s    = state_r;
        per_cnt_nxt_s  = per_cnt_r;
        hi_cnt_nxt_s   = hi_cnt_r;
        valid_nxt_s    = 1'b0;
        high_nxt_s     = high_o;
        period_nxt_s   = period_o;
        duty_nxt_s     = duty_o;
        frame_ok_nxt_s = frame_ok_o;
        stuck_nxt_s    = stuck_o;
        level_nxt_s    = level_o;
        if (rise_s) begin
            case (state_r)
                MEASURE: begin
                    valid_nxt_s    = 1'b1;
                    high_nxt_s     = hi_cnt_r;
                    period_nxt_s   = per_cnt_r;
                    duty_nxt_s     = duty_of(hi_cnt_r);
                    frame_ok_nxt_s = (per_cnt_r == FRAME_C);
                    stuck_nxt_s    = 1'b0;
                end
                SEARCH: begin
                    valid_nxt_s = 1'b0;
                end
                default: begin
                    valid_nxt_s = 1'b0;
                end
            endcase
            state_nxt_s   = MEASURE;
            per_cnt_nxt_s = ONE_C;
            hi_cnt_nxt_s  = ONE_C;
        end else if (per_cnt_r == TO_M1_C) begin
            valid_nxt_s    = 1'b1;
            stuck_nxt_s    = 1'b1;
            level_nxt_s    = s_s;
            duty_nxt_s     = s_s ? DUTY_W'(DUTY_MAX) : DUTY_W'(0);
            high_nxt_s     = s_s ? TO_C : ZERO_C;
            period_nxt_s   = TO_C;
            frame_ok_nxt_s = 1'b0;
            per_cnt_nxt_s  = ZERO_C;
            hi_cnt_nxt_s   = ZERO_C;
            state_nxt_s    = SEARCH;
        end else begin
            per_cnt_nxt_s = per_cnt_r + ONE_C;
            if (state_r == MEASURE) begin
                hi_cnt_nxt_s = hi_cnt_r + {{(CNT_W-1){1'b0}}, s_s};
            end else begin
                hi_cnt_nxt_s = hi_cnt_r;
            end
        end
    end

    // State, counters and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= SEARCH;
            s_prev_r   <= 1'b0;
            per_cnt_r  <= ZERO_C;
            hi_cnt_r   <= ZERO_C;
            valid_o    <= 1'b0;
            high_o     <= ZERO_C;
            period_o   <= ZERO_C;
            duty_o     <= DUTY_W'(0);
            frame_ok_o <= 1'b0;
            stuck_o    <= 1'b0;
            level_o    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            s_prev_r   <= s_s;
            per_cnt_r  <= per_cnt_nxt_s;
            hi_cnt_r   <= hi_cnt_nxt_s;
            valid_o    <= valid_nxt_s;
            high_o     <= high_nxt_s;
            period_o   <= period_nxt_s;
            duty_o     <= duty_nxt_s;
            frame_ok_o <= frame_ok_nxt_s;
            stuck_o    <= stuck_nxt_s;
            level_o    <= level_nxt_s;
        end
    end

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Randomized bench for pwm_duty_capture: a waveform history plus an edge-event
// reference model predicts every output on every clock.
module tb_pwm_duty_capture;

    localparam int TO   = 128;
    localparam int FR   = 64;
    localparam int MAXS = 32768;

    logic       clk;
    logic       rst;
    logic       pwm_in;
    logic       valid_o;
    logic [7:0] high_o;
    logic [7:0] period_o;
    logic [5:0] duty_o;
    logic       frame_ok_o;
    logic       stuck_o;
    logic       level_o;

    pwm_duty_capture #(.TIMEOUT(TO), .FRAME(FR)) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .valid_o    (valid_o),
        .high_o     (high_o),
        .period_o   (period_o),
        .duty_o     (duty_o),
        .frame_ok_o (frame_ok_o),
        .stuck_o    (stuck_o),
        .level_o    (level_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks_n;
    int   fails_n;
    int   step_n;
    logic vh [MAXS];

    int e_valid, e_high, e_period, e_duty, e_frame, e_stuck, e_level;
    int have_ref, last_r, deadline;

    task automatic check_val(input string tag, input int got, input int exp);
        checks_n++;
        if (got != exp) begin
            fails_n++;
            $display("FAIL %s step=%0d got=%0d exp=%0d", tag, step_n, got, exp);
        end
    endtask

    function automatic int hist(input int i);
        if (i < 0 || i >= MAXS) return 0;
        return int'(vh[i]);
    endfunction

    // Reference: results are defined by rise times of the synchronized line
    // (two clocks behind pwm_in) and the count of high samples between them.
    task automatic model_edge(input int e);
        int s_now, s_old, hi, per;
        if (rst) begin
            e_valid = 0; e_high = 0; e_period = 0; e_duty = 0;
            e_frame = 0; e_stuck = 0; e_level = 0;
            have_ref = 0;
            deadline = e + TO;
        end else begin
            s_now   = hist(e - 2);
            s_old   = hist(e - 3);
            e_valid = 0;
            if (s_now == 1 && s_old == 0) begin
                if (have_ref != 0) begin
                    per = e - last_r;
                    hi  = 0;
                    for (int i = last_r - 2; i <= e - 3; i++) hi += hist(i);
                    e_high   = hi;
                    e_period = per;
                    e_duty   = (hi - 1 > 63) ? 63 : hi - 1;
                    e_frame  = (per == FR) ? 1 : 0;
                    e_stuck  = 0;
                    e_valid  = 1;
                end
                have_ref = 1;
                last_r   = e;
                deadline = e + TO - 1;
            end else if (e == deadline) begin
                e_stuck  = 1;
                e_level  = s_now;
                e_duty   = (s_now != 0) ? 63 : 0;
                e_high   = (s_now != 0) ? TO : 0;
                e_period = TO;
                e_frame  = 0;
                e_valid  = 1;
                have_ref = 0;
                deadline = e + TO;
            end
        end
    endtask

    task automatic compare_all();
        check_val("valid",    int'(valid_o),    e_valid);
        check_val("high",     int'(high_o),     e_high);
        check_val("period",   int'(period_o),   e_period);
        check_val("duty",     int'(duty_o),     e_duty);
        check_val("frame_ok", int'(frame_ok_o), e_frame);
        check_val("stuck",    int'(stuck_o),    e_stuck);
        check_val("level",    int'(level_o),    e_level);
    endtask

    task automatic drive_step(input logic v);
        pwm_in = v;
        if (step_n < MAXS) vh[step_n] = rst ? 1'b0 : v;
        @(posedge clk);
        #1;
        model_edge(step_n);
        compare_all();
        step_n++;
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) drive_step(v);
    endtask

    task automatic frames(input int per, input int hi, input int cnt);
        for (int f = 0; f < cnt; f++)
            for (int i = 0; i < per; i++) drive_step(i < hi);
    endtask

    // Reset arrives asynchronously mid-cycle; outputs must clear before the next edge.
    task automatic reset_mid();
        pwm_in = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_val("rst_async_valid",  int'(valid_o),  0);
        check_val("rst_async_high",   int'(high_o),   0);
        check_val("rst_async_period", int'(period_o), 0);
        check_val("rst_async_duty",   int'(duty_o),   0);
        check_val("rst_async_stuck",  int'(stuck_o),  0);
        if (step_n < MAXS) vh[step_n] = 1'b0;
        @(posedge clk);
        #1;
        model_edge(step_n);
        compare_all();
        step_n++;
    endtask

    initial begin
        int per, hi;
        checks_n = 0; fails_n = 0; step_n = 0;
        e_valid = 0; e_high = 0; e_period = 0; e_duty = 0;
        e_frame = 0; e_stuck = 0; e_level = 0;
        have_ref = 0; last_r = 0; deadline = TO;
        rst = 1'b1;
        pwm_in = 1'b0;
        hold(1'b0, 3);
        rst = 1'b0;
        hold(1'b0, 10);

        frames(FR, 32, 6);
        frames(FR, 1, 4);
        frames(FR, 32, 1);
        hold(1'b1, 300);
        frames(100, 30, 4);
        frames(FR, 32, 4);

        frames(FR, 32, 2);
        hold(1'b1, 20);
        reset_mid();
        hold(1'b0, 3);
        rst = 1'b0;
        frames(FR, 32, 4);

        hold(1'b0, 300);
        frames(TO - 1, 40, 3);
        frames(TO, 40, 3);
        frames(TO - 2, 90, 3);

        for (int k = 0; k < 64; k++) frames(FR, int'($urandom_range(0, 63)) + 1, 1);

        for (int k = 0; k < 30; k++) begin
            per = int'($urandom_range(2, 200));
            hi  = int'($urandom_range(1, per - 1));
            frames(per, hi, int'($urandom_range(1, 2)));
        end
        hold(1'b0, 150);

        check_val("step_budget", int'(step_n < MAXS), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
        $finish;
    end

endmodule
